// File: rtl/bnn_fc_seq.sv
// bnn_fc_seq: binary fully-connected layer (XNOR-popcount), one neuron per cycle.
//
// A binarised feature vector of INPUT_NUM bits arrives in LANES-bit beats and
// is stored in a vector buffer. Each neuron k then scores as
// popcount(~(vector ^ W[k])). Scores stream out over a valid/ready handshake.
// The weight rows are loaded at run time, one row per write.
//
// Optional feature macro: ARGMAX_EN. When it is defined, the class_valid and
// class_idx outputs report the argmax of each frame.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      input beat valid
//   in_ready      beat accepted when in_valid && in_ready (high in FILL)
//   in_data       LANES bits; lane i of beat b is vector bit i*BEATS+b
//   w_valid       weight row write strobe
//   w_ready       write accepted when w_valid && w_ready (high in FILL)
//   w_row         target neuron row
//   w_data        weight row; bit j pairs with vector bit j
//   out_valid     score valid
//   out_ready     downstream accepts the score
//   out_data      match count, 0..INPUT_NUM
//   out_idx       neuron index of out_data
//   out_last      high with neuron OUTPUT_NUM-1
//   class_valid   (ARGMAX_EN) one-cycle pulse after the last score handshake
//   class_idx     (ARGMAX_EN) argmax of the frame; ties keep the lower index

module bnn_fc_seq #(
  parameter  int INPUT_NUM  = 400,
  parameter  int OUTPUT_NUM = 10,
  parameter  int LANES      = 16,
  localparam int BEATS      = INPUT_NUM / LANES,
  localparam int CNT_W      = $clog2(INPUT_NUM + 1),
  localparam int IDX_W      = $clog2(OUTPUT_NUM)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [LANES-1:0]     in_data,
  input  logic                 w_valid,
  output logic                 w_ready,
  input  logic [IDX_W-1:0]     w_row,
  input  logic [INPUT_NUM-1:0] w_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_last
`ifdef ARGMAX_EN
  ,
  output logic                 class_valid,
  output logic [IDX_W-1:0]     class_idx
`endif
);

  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(OUTPUT_NUM - 1);

  typedef enum logic [1:0] {FILL, COMPUTE, DRAIN} state_t;

  state_t               state_reg;
  logic [BEAT_W-1:0]    beat_cnt_reg;
  logic [IDX_W-1:0]     k_reg;

  logic [BEATS-1:0]     lane_reg [LANES];
  logic [INPUT_NUM-1:0] w_mem    [OUTPUT_NUM];
  logic [INPUT_NUM-1:0] vec;
  logic [INPUT_NUM-1:0] w_sel;
  logic [CNT_W-1:0]     score;

  logic in_fire;
  logic w_fire;
  logic out_load;

  // Both ready signals come straight from the state register.
  assign in_ready = (state_reg == FILL);
  assign w_ready  = (state_reg == FILL);
  assign in_fire  = in_valid && in_ready;
  assign w_fire   = w_valid && w_ready;
  assign out_load = !out_valid || out_ready;

  // Each lane owns a contiguous BEATS-bit slice of the vector. Beat b lands
  // at position b inside every slice, which gives the i*BEATS+b bit mapping.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_reg[gi] <= '0;
        end else if (in_fire) begin
          lane_reg[gi][beat_cnt_reg] <= in_data[gi];
        end
      end
      assign vec[gi*BEATS +: BEATS] = lane_reg[gi];
    end

    // Weight rows are cleared by reset, so they must be reloaded after it.
    // Writes to rows beyond OUTPUT_NUM-1 match no row and are dropped.
    for (gi = 0; gi < OUTPUT_NUM; gi++) begin : g_row
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          w_mem[gi] <= '0;
        end else if (w_fire && (w_row == IDX_W'(gi))) begin
          w_mem[gi] <= w_data;
        end
      end
    end
  endgenerate

  function automatic logic [CNT_W-1:0] popcount(input logic [INPUT_NUM-1:0] v);
    logic [CNT_W-1:0] s;
    s = '0;
    for (int j = 0; j < INPUT_NUM; j++) begin
      s = s + CNT_W'(v[j]);
    end
    return s;
  endfunction

  assign w_sel = w_mem[k_reg];
  assign score = popcount(~(vec ^ w_sel));

  // Control FSM with registered score outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= FILL;
      beat_cnt_reg <= '0;
      k_reg        <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_idx      <= '0;
      out_last     <= 1'b0;
    end else begin
      case (state_reg)
        FILL: begin
          if (in_valid) begin
            if (beat_cnt_reg == LAST_BEAT) begin
              beat_cnt_reg <= '0;
              state_reg    <= COMPUTE;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        COMPUTE: begin
          // The output register is refilled when empty or being consumed.
          // k does not advance while a score is stalled.
          if (out_load) begin
            out_data  <= score;
            out_idx   <= k_reg;
            out_last  <= (k_reg == LAST_IDX);
            out_valid <= 1'b1;
            if (k_reg == LAST_IDX) begin
              k_reg     <= '0;
              state_reg <= DRAIN;
            end else begin
              k_reg <= k_reg + 1'b1;
            end
          end
        end
        DRAIN: begin
          // The last score is still in the output register.
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state_reg <= FILL;
          end
        end
        default: state_reg <= FILL;
      endcase
    end
  end

`ifdef ARGMAX_EN
  logic [CNT_W-1:0] max_reg;
  logic [IDX_W-1:0] arg_reg;
  logic             out_fire;
  logic             better;
  logic [CNT_W-1:0] cand_max;
  logic [IDX_W-1:0] cand_idx;

  assign out_fire = out_valid && out_ready;

  // Neuron 0 restarts the running maximum for each frame. A strict
  // greater-than keeps the lower index when two scores tie.
  always_comb begin
    better   = (out_idx == '0) || (out_data > max_reg);
    cand_max = better ? out_data : max_reg;
    cand_idx = better ? out_idx  : arg_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_reg     <= '0;
      arg_reg     <= '0;
      class_valid <= 1'b0;
      class_idx   <= '0;
    end else begin
      class_valid <= out_fire && out_last;
      if (out_fire) begin
        max_reg <= cand_max;
        arg_reg <= cand_idx;
        if (out_last) begin
          class_idx <= cand_idx;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_bnn_fc_seq.sv
// tb_bnn_fc_seq: self-checking bench for bnn_fc_seq.
// A directed table of frames is followed by a backpressure case, a reset
// during COMPUTE, and randomized frames. The random frames are scored by a
// reference model that counts matching bits with $countones.
module tb_bnn_fc_seq;

  localparam int INPUT_NUM  = 400;
  localparam int OUTPUT_NUM = 10;
  localparam int LANES      = 16;
  localparam int BEATS      = INPUT_NUM / LANES;
  localparam int CNT_W      = $clog2(INPUT_NUM + 1);
  localparam int IDX_W      = $clog2(OUTPUT_NUM);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [LANES-1:0]     in_data = '0;
  logic                 w_valid = 1'b0;
  logic                 w_ready;
  logic [IDX_W-1:0]     w_row = '0;
  logic [INPUT_NUM-1:0] w_data = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [CNT_W-1:0]     out_data;
  logic [IDX_W-1:0]     out_idx;
  logic                 out_last;
`ifdef ARGMAX_EN
  logic                 class_valid;
  logic [IDX_W-1:0]     class_idx;
`endif

  always #5 clk = ~clk;

  bnn_fc_seq #(.INPUT_NUM(INPUT_NUM), .OUTPUT_NUM(OUTPUT_NUM), .LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .w_valid(w_valid), .w_ready(w_ready), .w_row(w_row), .w_data(w_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
`ifdef ARGMAX_EN
    , .class_valid(class_valid), .class_idx(class_idx)
`endif
  );

  int errors = 0;
  int checks = 0;
  logic [INPUT_NUM-1:0] w_model [OUTPUT_NUM];
  int exp_scores [OUTPUT_NUM];

  typedef struct {
    logic [INPUT_NUM-1:0] vec;
    logic [INPUT_NUM-1:0] w_all;
    bit                   load_w;
    int                   sp_row;
    logic [INPUT_NUM-1:0] w_sp;
    int                   exp_all;
    int                   exp_sp;
    int                   stall_at;
    int                   stall_len;
  } frame_t;

  frame_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [INPUT_NUM-1:0] rand_vec();
    logic [INPUT_NUM-1:0] v;
    for (int i = 0; i < INPUT_NUM; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Reference model: a score is the number of positions where the bits agree.
  task automatic model_scores(input logic [INPUT_NUM-1:0] v);
    for (int k = 0; k < OUTPUT_NUM; k++)
      exp_scores[k] = INPUT_NUM - $countones(v ^ w_model[k]);
  endtask

  task automatic load_all(input logic [INPUT_NUM-1:0] w_all, input int sp_row,
                          input logic [INPUT_NUM-1:0] w_sp);
    for (int r = 0; r < OUTPUT_NUM; r++) begin
      @(negedge clk);
      check("w_ready_fill", 64'(w_ready), 64'd1);
      w_valid = 1'b1;
      w_row   = IDX_W'(r);
      w_data  = (r == sp_row) ? w_sp : w_all;
      w_model[r] = w_data;
    end
    @(negedge clk);
    w_valid = 1'b0;
  endtask

  // Sends one frame. wr_row >= 0 also writes that weight row on beat 0.
  task automatic send_frame(input logic [INPUT_NUM-1:0] v, input int wr_row,
                            input logic [INPUT_NUM-1:0] wr_data);
    logic [LANES-1:0] beat;
    for (int b = 0; b < BEATS; b++) begin
      @(negedge clk);
      check("in_ready_fill", 64'(in_ready), 64'd1);
      for (int i = 0; i < LANES; i++) beat[i] = v[i*BEATS + b];
      in_valid = 1'b1;
      in_data  = beat;
      if (b == 0 && wr_row >= 0) begin
        w_valid = 1'b1;
        w_row   = IDX_W'(wr_row);
        w_data  = wr_data;
        w_model[wr_row] = wr_data;
      end else begin
        w_valid = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = '0;
    w_valid  = 1'b0;
  endtask

  // Consumes one frame of scores and compares them with exp_scores. The
  // score at stall_at is refused for stall_len cycles. With hold_w set,
  // w_valid stays high during COMPUTE and the DUT must ignore it.
  task automatic collect(input int stall_at, input int stall_len, input bit hold_w);
    int k = 0;
    int cyc = 0;
    int stalled = 0;
    logic [CNT_W-1:0] hd;
    logic [IDX_W-1:0] hi;
    int best = 0;
    check("lat_pre_valid", 64'(out_valid), 64'd0);
    check("in_ready_compute", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    if (hold_w) begin
      w_valid = 1'b1;
      w_row   = '0;
      w_data  = ~w_model[0];
    end
    while (k < OUTPUT_NUM && cyc < 200) begin
      @(negedge clk);
      cyc++;
      check("in_ready_busy", 64'(in_ready), 64'd0);
      check("w_ready_busy", 64'(w_ready), 64'd0);
      if (cyc == 1) check("first_lat", 64'(out_valid), 64'd1);
      if (out_valid) begin
        if (k == stall_at && stalled < stall_len) begin
          if (stalled == 0) begin
            hd = out_data;
            hi = out_idx;
          end else begin
            check("stall_data", 64'(out_data), 64'(hd));
            check("stall_idx", 64'(out_idx), 64'(hi));
          end
          out_ready = 1'b0;
          stalled++;
        end else begin
          out_ready = 1'b1;
          check("score", 64'(out_data), 64'(exp_scores[k]));
          check("idx", 64'(out_idx), 64'(k));
          check("last", 64'(out_last), 64'(k == OUTPUT_NUM - 1));
          if (k == OUTPUT_NUM - 1) w_valid = 1'b0;
          k++;
        end
      end
    end
    if (k < OUTPUT_NUM) check("collect_timeout", 64'(k), 64'(OUTPUT_NUM));
    @(negedge clk);
    w_valid = 1'b0;
    check("drain_valid", 64'(out_valid), 64'd0);
    check("in_ready_after", 64'(in_ready), 64'd1);
    check("w_ready_after", 64'(w_ready), 64'd1);
    for (int j = 1; j < OUTPUT_NUM; j++) if (exp_scores[j] > exp_scores[best]) best = j;
`ifdef ARGMAX_EN
    check("class_valid", 64'(class_valid), 64'd1);
    check("class_idx", 64'(class_idx), 64'(best));
`endif
    $display("frame: scores[0]=%0d scores[%0d]=%0d argmax=%0d stall_at=%0d len=%0d",
             exp_scores[0], OUTPUT_NUM - 1, exp_scores[OUTPUT_NUM - 1], best, stall_at, stall_len);
  endtask

  initial begin
    logic [INPUT_NUM-1:0] ones;
    logic [INPUT_NUM-1:0] zeros;
    logic [INPUT_NUM-1:0] alt;
    logic [INPUT_NUM-1:0] one_bit;
    logic [INPUT_NUM-1:0] v;
    ones    = {INPUT_NUM{1'b1}};
    zeros   = '0;
    alt     = {(INPUT_NUM/2){2'b10}};
    one_bit = '0;
    one_bit[(LANES-1)*BEATS] = 1'b1;  // beat 0, lane 15 -> bit 375
    for (int r = 0; r < OUTPUT_NUM; r++) w_model[r] = '0;

    tbl[0] = '{vec: ones,    w_all: ones,  load_w: 1, sp_row: -1, w_sp: zeros,
               exp_all: 400, exp_sp: 0,   stall_at: -1, stall_len: 0};
    tbl[1] = '{vec: ones,    w_all: zeros, load_w: 1, sp_row: -1, w_sp: zeros,
               exp_all: 0,   exp_sp: 0,   stall_at: -1, stall_len: 0};
    tbl[2] = '{vec: zeros,   w_all: zeros, load_w: 0, sp_row: -1, w_sp: zeros,
               exp_all: 400, exp_sp: 0,   stall_at: -1, stall_len: 0};
    tbl[3] = '{vec: ones,    w_all: ones,  load_w: 1, sp_row: 3,  w_sp: alt,
               exp_all: 400, exp_sp: 200, stall_at: 4,  stall_len: 5};
    tbl[4] = '{vec: one_bit, w_all: zeros, load_w: 1, sp_row: 0,  w_sp: one_bit,
               exp_all: 399, exp_sp: 400, stall_at: -1, stall_len: 0};

    // Reset state.
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_idx", 64'(out_idx), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_w_ready", 64'(w_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table.
    for (int t = 0; t < 5; t++) begin
      if (tbl[t].load_w) load_all(tbl[t].w_all, tbl[t].sp_row, tbl[t].w_sp);
      send_frame(tbl[t].vec, -1, zeros);
      for (int k = 0; k < OUTPUT_NUM; k++)
        exp_scores[k] = (k == tbl[t].sp_row) ? tbl[t].exp_sp : tbl[t].exp_all;
      collect(tbl[t].stall_at, tbl[t].stall_len, 1'b0);
    end

    // Reset while neuron 6 is on the output.
    load_all(ones, -1, zeros);
    send_frame(ones, -1, zeros);
    out_ready = 1'b1;
    for (int c = 0; c < 50 && !(out_valid && out_idx == IDX_W'(6)); c++) @(negedge clk);
    check("rst_reach_idx6", 64'(out_idx), 64'd6);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_w_ready", 64'(w_ready), 64'd1);
    check("midrst_out_idx", 64'(out_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < OUTPUT_NUM; r++) w_model[r] = '0;
    send_frame(zeros, -1, zeros);
    for (int k = 0; k < OUTPUT_NUM; k++) exp_scores[k] = INPUT_NUM;
    collect(-1, 0, 1'b0);

    // Random frames against the reference model, some with a weight write
    // on the first beat, backpressure, and w_valid held during COMPUTE.
    for (int n = 0; n < 6; n++) begin
      for (int r = 0; r < OUTPUT_NUM; r++) begin
        @(negedge clk);
        w_valid = 1'b1;
        w_row   = IDX_W'(r);
        w_data  = rand_vec();
        w_model[r] = w_data;
      end
      @(negedge clk);
      w_valid = 1'b0;
      v = rand_vec();
      send_frame(v, int'($urandom_range(0, OUTPUT_NUM - 1)), rand_vec());
      model_scores(v);
      collect(int'($urandom_range(0, OUTPUT_NUM - 1)), int'($urandom_range(0, 4)), n[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
